// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_activity_timer.sv
// Activity level: set by a done strobe, dropped after IDLE_TIMEOUT_CYC quiet cycles.
// Level rises one cycle after the strobe; a strobe on the timeout cycle keeps it high.
module uart_activity_timer #(
    parameter int IDLE_TIMEOUT_CYC = 5000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_done,
    output logic o_en
);

    localparam int CNT_W = (IDLE_TIMEOUT_CYC > 1) ? $clog2(IDLE_TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else if (i_done) begin
            r_cnt <= '0;
            r_en  <= 1'b1;
        end else if (r_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_en  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_en = r_en;

endmodule

// File: rtl/uart_rx_activity.sv
// 8N1 UART receiver (even parity with UART_PARITY_EN) plus line-activity level; no backpressure.
// rx_done/frame_err strobe one cycle after the mid-stop-bit sample (~9.5 bit periods + 3 cycles).
module uart_rx_activity
    import uart_pkg::*;
#(
    parameter int CLK_FREQ         = 50000000,
    parameter int BAUD             = 115200,
    parameter int IDLE_TIMEOUT_CYC = 5000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy,
    output logic       uart_en
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    logic                 r_s1, r_s2, r_s3;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_done;
    logic                 r_frame_err;

    rx_state_t w_state_nxt;
    logic      w_fall;
    logic      w_half_hit;
    logic      w_full_hit;
    logic      w_baud_clr;
    logic      w_bit_clr;
    logic      w_shift_en;
    logic      w_done_set;
    logic      w_ferr_set;
    logic      w_par_ok;

`ifdef UART_PARITY_EN
    logic r_par;
    logic w_par_en;
    assign w_par_ok = ~(^r_shift ^ r_par);
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_fall     = r_s3 & ~r_s2;
    assign w_half_hit = (r_baud_cnt == HALF_LAST);
    assign w_full_hit = (r_baud_cnt == FULL_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= uart_rxd;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_clr  = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_done_set  = 1'b0;
        w_ferr_set  = 1'b0;
`ifdef UART_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_baud_clr  = 1'b1;
                end
            end
            ST_START: begin
                // Mid start bit: a high line here means the edge was a glitch.
                if (w_half_hit) begin
                    w_baud_clr = 1'b1;
                    if (!r_s2) begin
                        w_state_nxt = ST_DATA;
                        w_bit_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_full_hit) begin
                    w_baud_clr = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (w_full_hit) begin
                    w_baud_clr  = 1'b1;
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (w_full_hit) begin
                    w_baud_clr  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_s2 && w_par_ok) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_ferr_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_done   <= w_done_set;
            r_frame_err <= w_ferr_set;
            if (w_baud_clr) begin
                r_baud_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift_en) begin
                r_shift[r_bit_cnt] <= r_s2;
            end
            if (w_done_set) begin
                r_rx_data <= r_shift;
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_par <= 1'b0;
        end else if (w_par_en) begin
            r_par <= r_s2;
        end
    end
`endif

    uart_activity_timer #(
        .IDLE_TIMEOUT_CYC (IDLE_TIMEOUT_CYC)
    ) u_activity (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst),
        .i_done  (r_rx_done),
        .o_en    (uart_en)
    );

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_activity.sv
// Directed bench for uart_rx_activity: 10 clocks per bit, 200-cycle idle timeout.
module tb_uart_rx_activity;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int IDLE     = 200;
    localparam int BIT      = 10;
    localparam int LAT      = 98;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;
    logic       uart_en;

    uart_rx_activity #(
        .CLK_FREQ         (CLK_FREQ),
        .BAUD             (BAUD),
        .IDLE_TIMEOUT_CYC (IDLE)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .uart_en   (uart_en)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected strobes, each tagged with the cycle it must appear in.
    typedef struct {
        int         at;
        bit         good;
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    ev_t        m_ev;
    logic [7:0] m_data = 8'h00;
    bit         m_have = 1'b0;
    int         m_last = 0;
    bit         e_done, e_ferr, e_en;

    int n_done = 0;
    int n_ferr = 0;
    int last_done_cyc = 0;
    int busy_cnt = 0;
    int en_rise_cyc = 0;
    bit prev_en = 1'b0;

    // uart_en must be high exactly in the IDLE cycles following the latest good byte.
    always @(negedge sys_clk) begin
        e_done = 1'b0;
        e_ferr = 1'b0;
        if (!sys_rst) begin
            evq.delete();
            m_have = 1'b0;
            m_data = 8'h00;
            e_en   = 1'b0;
        end else begin
            e_en = m_have && (cyc - m_last > 0) && (cyc - m_last <= IDLE);
            if (evq.size() > 0 && evq[0].at == cyc) begin
                m_ev = evq.pop_front();
                if (m_ev.good) begin
                    e_done = 1'b1;
                    m_data = m_ev.d;
                    m_have = 1'b1;
                    m_last = cyc;
                end else begin
                    e_ferr = 1'b1;
                end
            end
        end
        check("rx_done",   32'(rx_done),   32'(e_done));
        check("frame_err", 32'(frame_err), 32'(e_ferr));
        check("uart_en",   32'(uart_en),   32'(e_en));
        check("rx_data",   32'(rx_data),   32'(m_data));
        if (rx_done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) n_ferr++;
        if (rx_busy === 1'b1) busy_cnt++;
        if (uart_en === 1'b1 && !prev_en) en_rise_cyc = cyc;
        prev_en = (uart_en === 1'b1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        ev_t e;
        e.at   = cyc + LAT;
        e.good = stop_ok;
        e.d    = d;
        evq.push_back(e);
        uart_rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_cyc(BIT);
        end
        uart_rxd = stop_ok;
        wait_cyc(BIT);
        uart_rxd = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nb, fb, n1, d1, n2, d2, d3, nr;
        byte unsigned b81;

        wait_cyc(3);
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_done",   32'(rx_done),   32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_rx_busy",   32'(rx_busy),   32'h0);
        check("rst_uart_en",   32'(uart_en),   32'h0);
        sys_rst = 1'b1;
        wait_cyc(5);

        n0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cyc(2);
        check("a5_count",   32'(n_done), 32'd1);
        check("a5_latency", 32'(last_done_cyc - n0), 32'd98);
        check("a5_data",    32'(rx_data), 32'hA5);
        check("a5_en_rise", 32'(en_rise_cyc - last_done_cyc), 32'd1);
        check("a5_busy",    32'(rx_busy), 32'h0);
        wait_cyc(250);

        nb = n_done;
        fb = n_ferr;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_cyc(3);
        check("b2b_count", 32'(n_done - nb), 32'd3);
        check("b2b_ferr",  32'(n_ferr - fb), 32'd0);
        check("b2b_data",  32'(rx_data), 32'h3C);
        check("b2b_en",    32'(uart_en), 32'h1);

        nb = n_done;
        busy_cnt = 0;
        uart_rxd = 1'b0;
        wait_cyc(3);
        uart_rxd = 1'b1;
        wait_cyc(20);
        check("glitch_busy", 32'(busy_cnt), 32'd5);
        check("glitch_done", 32'(n_done - nb), 32'd0);
        check("glitch_ferr", 32'(n_ferr - fb), 32'd0);

        send_frame(8'h55, 1'b0);
        wait_cyc(3);
        check("stop_low_ferr", 32'(n_ferr - fb), 32'd1);
        check("stop_low_done", 32'(n_done - nb), 32'd0);
        check("stop_low_data", 32'(rx_data), 32'h3C);
        wait_cyc(250);

        n1 = cyc;
        d1 = n1 + LAT;
        send_frame(8'h12, 1'b1);
        wait_cyc(d1 + IDLE - cyc);
        check("timeout_last_hi", 32'(uart_en), 32'h1);
        wait_cyc(1);
        check("timeout_drop", 32'(uart_en), 32'h0);

        n2 = cyc;
        d2 = n2 + LAT;
        send_frame(8'h34, 1'b1);
        wait_cyc(d2 + IDLE - LAT - cyc);
        d3 = cyc + LAT;
        send_frame(8'h56, 1'b1);
        check("coincide_cyc",  32'(d3 - d2), 32'd200);
        check("coincide_done", 32'(last_done_cyc), 32'(d3));
        check("coincide_en",   32'(uart_en), 32'h1);
        check("coincide_data", 32'(rx_data), 32'h56);

        b81 = 8'h81;
        uart_rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = b81[i];
            wait_cyc(BIT);
        end
        uart_rxd = b81[4];
        wait_cyc(3);
        nr = n_done;
        sys_rst  = 1'b0;
        uart_rxd = 1'b1;
        #1;
        check("midrst_data", 32'(rx_data),   32'h00);
        check("midrst_done", 32'(rx_done),   32'h0);
        check("midrst_ferr", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(rx_busy),   32'h0);
        check("midrst_en",   32'(uart_en),   32'h0);
        wait_cyc(3);
        sys_rst = 1'b1;
        wait_cyc(5);
        check("midrst_nostrobe", 32'(n_done - nr), 32'd0);
        send_frame(8'h81, 1'b1);
        wait_cyc(3);
        check("after_rst_count", 32'(n_done - nr), 32'd1);
        check("after_rst_data",  32'(rx_data), 32'h81);
        check("after_rst_en",    32'(uart_en), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
